mbist_fail_log: RTL
===================

Name: mbist_fail_log

Overview:
Failure-capture stage directly downstream of the mbist top.
- Consumes the per-compare error strobe together with the failing address, the selected memory and the read-vs-expected XOR syndrome.
- Logs each failure into a small show-ahead FIFO, counts all failures and flags overflow.
- Exposes the entries through a valid/ready readout port to the test access logic or a diagnosis engine.

Parameters:
ADDR_WIDTH, 16, width of failing address and of fail counter
DATA_WIDTH, 64, width of XOR syndrome (power of 2)
DEPTH, 8, FIFO entries (power of 2, >=2)
SEL_WIDTH, 3, width of memory_sel

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
test_mode  input  1  MBIST session enable; rising edge starts a new session
fail_valid  input  1  one-cycle strobe: compare mismatch this cycle
fail_addr  input  ADDR_WIDTH  failing address
fail_sel  input  SEL_WIDTH  memory_sel of failing memory
fail_xor  input  DATA_WIDTH  rdata XOR expected data (nonzero when fail_valid)
complete  input  1  end-of-test pulse from controller
log_ready  input  1  consumer accepts head entry
log_valid  output  1  head entry valid
log_addr  output  ADDR_WIDTH  head entry address
log_sel  output  SEL_WIDTH  head entry memory_sel
log_bit  output  $clog2(DATA_WIDTH)  lowest failing bit index of head entry
log_multi  output  1  head entry had >1 failing bit
fail_count  output  ADDR_WIDTH  total failures this session, saturating
overflow  output  1  sticky: a failure was dropped because FIFO was full
done  output  1  session complete and FIFO drained

Behaviour:
Reset (rst_n low, async):
- FSM to IDLE; FIFO pointers and occupancy to 0.
- log_valid, log_addr, log_sel, log_bit, log_multi, fail_count, overflow, done all 0.
- test_mode edge register to 0.

test_mode rising edge: detected with one register, acting in the cycle after test_mode is first sampled high.

FSM:
- IDLE: fail_valid ignored. On test_mode rising edge: clear FIFO, fail_count, overflow and done; go to CAPTURE.
- CAPTURE: fail_valid is logged. complete=1 -> DRAIN. A fail_valid in the same cycle as complete is still logged.
- DRAIN: fail_valid ignored. done=1 whenever the FIFO is empty.
- Any state: test_mode=0 -> IDLE. FIFO contents, fail_count and overflow are retained and stay readable. done holds its value.
- New rising edge in IDLE clears everything for the next session.

Capture, per accepted fail_valid in CAPTURE:
- fail_count += 1, saturating at all-ones.
- Duplicate check: if fail_addr and fail_sel equal the last pushed entry (valid only since session start), nothing is pushed.
- Otherwise push {addr, sel, bit, multi}.
  - bit = index of the lowest set bit of fail_xor.
  - multi = 1 when more than one bit of fail_xor is set.
- Full FIFO and no pop this cycle: entry dropped, overflow set (sticky).
- Full FIFO with a simultaneous pop: push accepted.

Readout (show-ahead):
- log_* reflect the FIFO head, driven from registered storage.
- log_valid = FIFO not empty.
- A pop occurs when log_valid and log_ready are both 1.
- Latency: fail_valid at edge N with empty FIFO -> log_valid=1 after edge N+1.
- Push and pop together: occupancy unchanged, pointers wrap modulo DEPTH.
- Pop while empty: no effect.
- Pops are allowed in every state.

Decomposition:
Shared package mbist_pkg holds:
- FSM state encoding: IDLE=2'd0, CAPTURE=2'd1, DRAIN=2'd2.
- Log entry field widths/packing order: {addr, sel, bit, multi}.

One sub-module, mbist_bit_prio_enc (combinational, parameter DATA_WIDTH):
- Lowest-set-bit index plus a more-than-one-bit flag.
- Instantiated once on fail_xor.

The FIFO is inline.

Test Plan:
1. Reset mid-CAPTURE holding 3 entries -> all outputs 0 immediately, state IDLE; fail_valid ignored until a new test_mode rising edge.
2. test_mode rise; three fails addr 0x0010/0x0011/0x0012, sel 2, xor 0x1, 0x80, 0x6; log_ready=0 -> log_valid=1 one cycle after the first fail; fail_count=3; entries read in order with bits 0, 7, 1 and multi 0, 0, 1.
3. Duplicate fail at addr 0x0020 sel 1, twice back-to-back -> fail_count=2, only one entry logged.
4. DEPTH=8, ten distinct fails, log_ready=0 -> 8 entries logged, overflow=1, fail_count=10. Ninth fail with log_ready=1 in the same cycle while full -> accepted, no overflow from that fail.
5. complete pulse with 2 entries pending -> fail_valid afterwards ignored; done stays 0 until the second pop, then done=1.
6. fail_count preloaded near max via 0xFFFF fails (ADDR_WIDTH=16) plus one more -> fail_count holds at 0xFFFF.

Source files
------------

// File: rtl/mbist_pkg.sv
// Shared definitions for the MBIST failure-capture stage: FSM encoding and
// the packing of a logged failure entry {addr, sel, bit, multi}.
package mbist_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;

  // Entry layout, MSB first: addr, sel, lowest failing bit index, multi flag.
  function automatic int entry_width(input int addr_w, input int sel_w, input int bit_w);
    return addr_w + sel_w + bit_w + 1;
  endfunction

endpackage

// File: rtl/mbist_bit_prio_enc.sv
// Lowest-set-bit encoder for an XOR syndrome, plus a flag telling whether
// more than one bit of the syndrome is set.
module mbist_bit_prio_enc #(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0]         data,
  output logic [$clog2(DATA_WIDTH)-1:0] idx,
  output logic                          multi
);

  localparam int BW = $clog2(DATA_WIDTH);

  // Scanning from the top down leaves the lowest set bit as the final winner.
  always_comb begin
    idx = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (data[i]) idx = BW'(i);
    end
  end

  // Clearing the lowest set bit leaves something only if another bit was set.
  assign multi = |(data & (data - DATA_WIDTH'(1)));

endmodule

// File: rtl/mbist_fail_log.sv
// Failure logger behind the MBIST controller: counts compare failures, logs
// unique ones into a show-ahead FIFO and presents them on a valid/ready port.
module mbist_fail_log
  import mbist_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8,
  parameter int SEL_WIDTH  = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          test_mode,
  input  logic                          fail_valid,
  input  logic [ADDR_WIDTH-1:0]         fail_addr,
  input  logic [SEL_WIDTH-1:0]          fail_sel,
  input  logic [DATA_WIDTH-1:0]         fail_xor,
  input  logic                          complete,
  input  logic                          log_ready,
  output logic                          log_valid,
  output logic [ADDR_WIDTH-1:0]         log_addr,
  output logic [SEL_WIDTH-1:0]          log_sel,
  output logic [$clog2(DATA_WIDTH)-1:0] log_bit,
  output logic                          log_multi,
  output logic [ADDR_WIDTH-1:0]         fail_count,
  output logic                          overflow,
  output logic                          done,
  output logic [1:0]                    state
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = entry_width(ADDR_WIDTH, SEL_WIDTH, BW);

  logic [EW-1:0]         mem [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW:0]           count, count_nxt;
  logic                  tm_q, tm_rise, session_start;
  logic [1:0]            state_nxt;
  logic                  last_vld;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [SEL_WIDTH-1:0]  last_sel;
  logic [BW-1:0]         enc_bit;
  logic                  enc_multi;
  logic                  accept, dup, push_req, full, push, pop, drop;

  mbist_bit_prio_enc #(.DATA_WIDTH(DATA_WIDTH)) u_enc (
    .data  (fail_xor),
    .idx   (enc_bit),
    .multi (enc_multi)
  );

  assign tm_rise       = test_mode && !tm_q;
  assign session_start = (state == ST_IDLE) && tm_rise;

  always_comb begin
    state_nxt = state;
    if (!test_mode) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (tm_rise) state_nxt = ST_CAPTURE;
        ST_CAPTURE: if (complete) state_nxt = ST_DRAIN;
        ST_DRAIN:   state_nxt = ST_DRAIN;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  // Readout handshake: an entry transfers on a clock edge where log_valid and
  // log_ready are both high; log_valid never depends on log_ready.
  assign log_valid = (count != '0);
  assign {log_addr, log_sel, log_bit, log_multi} = mem[rd_ptr];

  assign accept   = (state == ST_CAPTURE) && fail_valid;
  assign dup      = last_vld && (fail_addr == last_addr) && (fail_sel == last_sel);
  assign push_req = accept && !dup;
  assign full     = (count == (PW + 1)'(DEPTH));
  assign pop      = log_valid && log_ready;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + (PW + 1)'(1);
      2'b01:   count_nxt = count - (PW + 1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tm_q       <= 1'b0;
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fail_count <= '0;
      overflow   <= 1'b0;
      done       <= 1'b0;
      last_vld   <= 1'b0;
      last_addr  <= '0;
      last_sel   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      tm_q  <= test_mode;
      state <= state_nxt;
      if (session_start) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        fail_count <= '0;
        overflow   <= 1'b0;
        done       <= 1'b0;
        last_vld   <= 1'b0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= {fail_addr, fail_sel, enc_bit, enc_multi};
          wr_ptr      <= wr_ptr + PW'(1);
          last_vld    <= 1'b1;
          last_addr   <= fail_addr;
          last_sel    <= fail_sel;
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count_nxt;
        if (accept && (fail_count != '1)) fail_count <= fail_count + ADDR_WIDTH'(1);
        if (drop) overflow <= 1'b1;
        // done tracks FIFO emptiness only while draining; leaving to IDLE keeps it.
        if (state_nxt == ST_DRAIN) done <= (count_nxt == '0);
      end
    end
  end

endmodule
